// File: rtl/caliptra_verilated_apb_master.sv
// APB3 initiator for the verilated Caliptra top.
// It takes one request at a time over a valid/ready channel and runs a
// SETUP/ACCESS sequence. The result comes back on a response channel.
// A bounded wait-state counter aborts transfers to a slave that never
// raises pready. All outputs decode from registered state.
module caliptra_verilated_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              core_clk,
  input  logic              cptra_rst_b,
  // request channel from the harness
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [USER_W-1:0] req_user,
  // response channel to the harness
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [31:0]       txn_count,
  // APB initiator side
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [USER_W-1:0] pauser,
  output logic [2:0]        pprot,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              req_ready_reg, req_ready_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [USER_W-1:0] user_reg, user_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]  wait_cnt_inc;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_slverr_reg, rsp_slverr_next;
  logic              rsp_timeout_reg, rsp_timeout_next;
  logic [31:0]       txn_count_reg, txn_count_next;

  // State and datapath registers; reset drops every strobe at once
  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_reg       <= ST_IDLE;
      req_ready_reg   <= 1'b0;
      write_reg       <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      user_reg        <= '0;
      wait_cnt_reg    <= '0;
      rsp_rdata_reg   <= '0;
      rsp_slverr_reg  <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      txn_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      req_ready_reg   <= req_ready_next;
      write_reg       <= write_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      user_reg        <= user_next;
      wait_cnt_reg    <= wait_cnt_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_slverr_reg  <= rsp_slverr_next;
      rsp_timeout_reg <= rsp_timeout_next;
      txn_count_reg   <= txn_count_next;
    end
  end

  // Next-state logic: latch the request, wait for pready or timeout, hold the response
  always_comb begin
    state_next       = state_reg;
    write_next       = write_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    user_next        = user_reg;
    wait_cnt_next    = wait_cnt_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_slverr_next  = rsp_slverr_reg;
    rsp_timeout_next = rsp_timeout_reg;
    txn_count_next   = txn_count_reg;
    wait_cnt_inc     = wait_cnt_reg + CNT_W'(1);

    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready_reg) begin
          write_next    = req_write;
          addr_next     = req_addr;
          wdata_next    = req_wdata;
          user_next     = req_user;
          wait_cnt_next = '0;
          state_next    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // pready is not sampled in SETUP; the slave only sees psel here
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_rdata_next   = write_reg ? '0 : prdata;
          rsp_slverr_next  = pslverr;
          rsp_timeout_next = 1'b0;
          state_next       = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt_inc;
          if (wait_cnt_inc == CNT_LIMIT) begin
            // Abandon the hung slave; psel/penable drop without a completed handshake
            rsp_rdata_next   = '0;
            rsp_slverr_next  = 1'b1;
            rsp_timeout_next = 1'b1;
            state_next       = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          txn_count_next = txn_count_reg + 32'd1;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // req_ready is registered so that it stays low while reset is held
    req_ready_next = (state_next == ST_IDLE);
  end

  assign req_ready   = req_ready_reg;
  assign psel        = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
  assign penable     = (state_reg == ST_ACCESS);
  assign paddr       = psel ? addr_reg  : '0;
  assign pwrite      = psel ? write_reg : 1'b0;
  assign pwdata      = psel ? wdata_reg : '0;
  assign pauser      = psel ? user_reg  : '0;
  assign pprot       = 3'b000;
  assign rsp_valid   = (state_reg == ST_RESP);
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_slverr  = rsp_slverr_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign txn_count   = txn_count_reg;

endmodule

// File: tb/tb_caliptra_verilated_apb_master.sv
// Directed testbench for caliptra_verilated_apb_master.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_caliptra_verilated_apb_master;

  logic        core_clk;
  logic        cptra_rst_b;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_user;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] txn_count;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] pauser;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int tests_run;
  int tests_failed;
  int pen_cnt;
  logic hold_ok;

  caliptra_verilated_apb_master #(
    .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .core_clk(core_clk), .cptra_rst_b(cptra_rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .txn_count(txn_count),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pauser(pauser),
    .pprot(pprot), .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Hard stop in case the sequence below stalls
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request; returns on the falling edge after the accepting edge (SETUP)
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] user);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_user  = user;
    req_valid = 1'b1;
    @(negedge core_clk);
    req_valid = 1'b0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    cptra_rst_b = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_user = 0;
    rsp_ready = 0; pready = 0; pslverr = 0; prdata = 0;

    // Reset state
    repeat (2) @(negedge core_clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_pprot", pprot, 0);
    cptra_rst_b = 1'b1;
    @(negedge core_clk);
    check("rst_rel_req_ready", req_ready, 1);
    $display("[TB] reset done");

    // 1: write with pready tied high, minimum latency
    pready = 1; rsp_ready = 1;
    do_req(1'b1, 32'h3003_0000, 32'hDEAD_BEEF, 32'h0000_00AA);
    check("t1_setup_psel", psel, 1);
    check("t1_setup_penable", penable, 0);
    check("t1_paddr", paddr, 32'h3003_0000);
    check("t1_pwdata", pwdata, 32'hDEAD_BEEF);
    check("t1_pwrite", pwrite, 1);
    check("t1_pauser", pauser, 32'h0000_00AA);
    check("t1_req_ready_busy", req_ready, 0);
    @(negedge core_clk);
    check("t1_access_penable", penable, 1);
    check("t1_access_pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge core_clk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_slverr", rsp_slverr, 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    check("t1_psel_low", psel, 0);
    check("t1_paddr_idle", paddr, 0);
    @(negedge core_clk);
    check("t1_txn_count", txn_count, 1);
    check("t1_req_ready_back", req_ready, 1);
    $display("[TB] txn1 write 30030000 txn_count=%0d", txn_count);

    // 2: read with five wait states
    rsp_ready = 0;
    do_req(1'b0, 32'h3003_0010, 32'h0, 32'h0);
    pready = 0; prdata = 32'h1234_5678; pen_cnt = 0;
    repeat (30) begin
      @(negedge core_clk);
      if (penable) begin
        pen_cnt++;
        check("t2_paddr_stable", paddr, 32'h3003_0010);
        pready = (pen_cnt == 6);
      end
    end
    check("t2_penable_cycles", pen_cnt, 6);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("t2_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1; pready = 1;
    @(negedge core_clk);
    check("t2_txn_count", txn_count, 2);
    $display("[TB] txn2 read 30030010 rdata=%h", rsp_rdata);

    // 3: read completing with a slave error
    rsp_ready = 0; pslverr = 1; prdata = 32'hA5A5_A5A5;
    do_req(1'b0, 32'h3003_0014, 32'h0, 32'h0);
    repeat (2) @(negedge core_clk);
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_slverr", rsp_slverr, 1);
    check("t3_rsp_timeout", rsp_timeout, 0);
    check("t3_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
    rsp_ready = 1; pslverr = 0;
    @(negedge core_clk);
    check("t3_txn_count", txn_count, 3);
    $display("[TB] txn3 read slverr=%0b", rsp_slverr);

    // 4: slave never ready -> abort after 16 ACCESS cycles
    rsp_ready = 0; pready = 0; prdata = 32'hFFFF_0000;
    do_req(1'b0, 32'h3003_0020, 32'h0, 32'h0);
    pen_cnt = 0;
    repeat (40) begin
      @(negedge core_clk);
      if (penable) pen_cnt++;
    end
    check("t4_penable_cycles", pen_cnt, 16);
    check("t4_psel_dropped", psel, 0);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_timeout", rsp_timeout, 1);
    check("t4_rsp_slverr", rsp_slverr, 1);
    check("t4_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    @(negedge core_clk);
    check("t4_txn_count", txn_count, 4);
    $display("[TB] txn4 timeout txn_count=%0d", txn_count);
    pready = 1;
    do_req(1'b1, 32'h3003_0024, 32'h1111_2222, 32'h0);
    repeat (2) @(negedge core_clk);
    check("t4b_rsp_valid", rsp_valid, 1);
    check("t4b_rsp_timeout", rsp_timeout, 0);
    check("t4b_rsp_slverr", rsp_slverr, 0);
    @(negedge core_clk);
    check("t4b_txn_count", txn_count, 5);
    $display("[TB] txn5 write after timeout ok");

    // 5: response back-pressure with the next request already waiting
    rsp_ready = 0; prdata = 32'h0BAD_F00D;
    req_write = 0; req_addr = 32'h3003_0028; req_valid = 1;
    @(negedge core_clk);
    req_addr = 32'h3003_0030;
    check("t5_req_ready_busy", req_ready, 0);
    repeat (2) @(negedge core_clk);
    prdata = 32'h0;
    hold_ok = 1'b1;
    repeat (10) begin
      @(negedge core_clk);
      if (!(rsp_valid === 1'b1 && rsp_rdata === 32'h0BAD_F00D && req_ready === 1'b0 &&
            psel === 1'b0 && rsp_slverr === 1'b0)) hold_ok = 1'b0;
    end
    check("t5_hold_stable", hold_ok, 1);
    rsp_ready = 1;
    @(negedge core_clk);
    check("t5_idle_req_ready", req_ready, 1);
    check("t5_idle_psel", psel, 0);
    check("t5_txn_count", txn_count, 6);
    @(negedge core_clk);
    req_valid = 0;
    check("t5_second_psel", psel, 1);
    check("t5_second_paddr", paddr, 32'h3003_0030);
    repeat (2) @(negedge core_clk);
    check("t5_second_rsp_valid", rsp_valid, 1);
    @(negedge core_clk);
    check("t5_second_txn_count", txn_count, 7);
    $display("[TB] txn6/7 back-pressure txn_count=%0d", txn_count);

    // 6: asynchronous reset in the middle of ACCESS
    pready = 0;
    do_req(1'b1, 32'h3003_0040, 32'hCAFE_0001, 32'h0);
    @(negedge core_clk);
    check("t6_in_access", penable, 1);
    #1 cptra_rst_b = 1'b0;
    #1;
    check("t6_psel_async", psel, 0);
    check("t6_penable_async", penable, 0);
    check("t6_rsp_valid_async", rsp_valid, 0);
    check("t6_txn_count_async", txn_count, 0);
    check("t6_paddr_async", paddr, 0);
    @(negedge core_clk);
    cptra_rst_b = 1'b1; pready = 1;
    @(negedge core_clk);
    check("t6_req_ready_after", req_ready, 1);
    check("t6_txn_count_after", txn_count, 0);
    check("t6_rsp_valid_after", rsp_valid, 0);
    $display("[TB] txn8 aborted by reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
